// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding and legal operand-width bounds.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder used as the serial datapath slice.
// Purely combinational; the controller owns all state.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands in over valid/ready,
// one bit per clock through a shared full adder, result out.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             ovf_q;

  logic fa_s;
  logic fa_co;
  logic last;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_valid) state_d = RUN;
      RUN:  if (last)    state_d = DONE;
      DONE: if (i_ready) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_valid) begin
        a_q     <= i_a;
        b_q     <= i_b;
        carry_q <= i_cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        // New sum bit enters at the MSB so bit 0 ends up as the LSB.
        sum_q   <= (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CW'(1);
        if (last) ovf_q <= carry_q ^ fa_co;
      end
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == RUN);
  assign o_valid = (state_q == DONE);
  assign o_sum   = sum_q;
  assign o_cout  = carry_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH 4, 8 and 1.
// Expected values are hand computed per vector.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  logic       v4, r4, ov4, ir4, c4, co4, of4, b4;
  logic [3:0] a4, bb4, s4;
  logic       v8, r8, ov8, ir8, c8, co8, of8, b8;
  logic [7:0] a8, bb8, s8;
  logic       v1, r1, ov1, ir1, c1, co1, of1, b1;
  logic [0:0] a1, bb1, s1;

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(r4),
    .i_a(a4), .i_b(bb4), .i_cin(c4), .o_valid(ov4),
    .i_ready(ir4), .o_sum(s4), .o_cout(co4), .o_ovf(of4),
    .o_busy(b4)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8),
    .i_a(a8), .i_b(bb8), .i_cin(c8), .o_valid(ov8),
    .i_ready(ir8), .o_sum(s8), .o_cout(co8), .o_ovf(of8),
    .o_busy(b8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1),
    .i_a(a1), .i_b(bb1), .i_cin(c1), .o_valid(ov1),
    .i_ready(ir1), .o_sum(s1), .o_cout(co1), .o_ovf(of1),
    .o_busy(b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int busy_n;

  initial begin
    rst = 1'b1;
    {v4, ir4, c4, a4, bb4} = '0;
    {v8, ir8, c8, a8, bb8} = '0;
    {v1, ir1, c1, a1, bb1} = '0;
    #12;
    chk("rst_ready4", r4, 1);
    chk("rst_valid4", ov4, 0);
    chk("rst_busy4", b4, 0);
    chk("rst_sum8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_ovf8", of8, 0);
    @(negedge clk);
    rst = 1'b0;

    // W4: 3+5+0 -> 8, cout 0, ovf 1
    @(negedge clk);
    a4 = 4'd3; bb4 = 4'd5; c4 = 1'b0; v4 = 1'b1; ir4 = 1'b1;
    tick;
    v4 = 1'b0;
    chk("t1_busy_T", b4, 1);
    chk("t1_ready_T", r4, 0);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("t1_novalid", ov4, 0);
    end
    tick;
    chk("t1_valid", ov4, 1);
    chk("t1_busy_done", b4, 0);
    chk("t1_sum", s4, 8);
    chk("t1_cout", co4, 0);
    chk("t1_ovf", of4, 1);
    tick;
    chk("t1_idle", r4, 1);
    chk("t1_valid_off", ov4, 0);

    // W4: 15+0+1 -> 0, cout 1, ovf 0, busy 4 cycles
    a4 = 4'd15; bb4 = 4'd0; c4 = 1'b1; v4 = 1'b1;
    tick;
    v4 = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20 && !ov4; i++) begin
      if (b4) busy_n++;
      tick;
    end
    chk("t2_valid", ov4, 1);
    chk("t2_busy_cycles", busy_n, 4);
    chk("t2_sum", s4, 0);
    chk("t2_cout", co4, 1);
    chk("t2_ovf", of4, 0);
    tick;

    // W8: 200+100 with backpressure, junk i_valid in DONE
    a8 = 8'd200; bb8 = 8'd100; c8 = 1'b0; v8 = 1'b1; ir8 = 1'b0;
    tick;
    v8 = 1'b0;
    repeat (8) tick;
    chk("t3_valid", ov8, 1);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'd1; bb8 = 8'd2; v8 = 1'b1;
      tick;
      chk("t3_hold_valid", ov8, 1);
      chk("t3_hold_sum", s8, 44);
      chk("t3_hold_cout", co8, 1);
      chk("t3_hold_ovf", of8, 0);
      chk("t3_hold_ready", r8, 0);
    end
    v8 = 1'b0; ir8 = 1'b1;
    tick;
    chk("t3_idle", r8, 1);
    chk("t3_valid_off", ov8, 0);

    // W8: i_valid pulses during RUN ignored; 10+20 -> 30
    a8 = 8'd10; bb8 = 8'd20; v8 = 1'b1; ir8 = 1'b0;
    tick;
    a8 = 8'd99; bb8 = 8'd99; c8 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("t4_run_ready", r8, 0);
    end
    tick;
    v8 = 1'b0; c8 = 1'b0;
    chk("t4_valid", ov8, 1);
    chk("t4_sum", s8, 30);
    chk("t4_cout", co8, 0);
    ir8 = 1'b1;
    tick;
    chk("t4_idle", r8, 1);

    // W8: reset two cycles into RUN, then 1+1 -> 2
    a8 = 8'd7; bb8 = 8'd9; v8 = 1'b1; ir8 = 1'b1;
    tick;
    v8 = 1'b0;
    repeat (2) tick;
    chk("t5_busy_pre", b8, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", r8, 1);
    chk("t5_rst_busy", b8, 0);
    chk("t5_rst_valid", ov8, 0);
    chk("t5_rst_sum", s8, 0);
    chk("t5_rst_cout", co8, 0);
    chk("t5_rst_ovf", of8, 0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("t5_post_idle", r8, 1);
    chk("t5_post_novalid", ov8, 0);
    a8 = 8'd1; bb8 = 8'd1; c8 = 1'b0; v8 = 1'b1;
    tick;
    v8 = 1'b0;
    repeat (8) tick;
    chk("t5_valid", ov8, 1);
    chk("t5_sum", s8, 2);
    chk("t5_cout", co8, 0);
    tick;

    // W1: 1+1+1 -> sum 1, cout 1, ovf 0
    a1 = 1'b1; bb1 = 1'b1; c1 = 1'b1; v1 = 1'b1; ir1 = 1'b1;
    tick;
    v1 = 1'b0;
    chk("t6_busy", b1, 1);
    tick;
    chk("t6_valid", ov1, 1);
    chk("t6_sum", s1, 1);
    chk("t6_cout", co1, 1);
    chk("t6_ovf", of1, 0);
    tick;
    chk("t6_idle", r1, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It feeds them LSB-first through a single shared FullAdder cell, one bit per clock, with a registered carry. It returns the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake. It sits between an operand producer and a result consumer wherever area matters more than add latency.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 1..64.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operands present on i_a/i_b/i_cin.
- o_ready  output  1  block can accept operands; high only in IDLE.
- i_a  input  WIDTH  operand A (unsigned or two's complement).
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in.
- o_valid  output  1  result present; high only in DONE.
- i_ready  input  1  consumer accepts result.
- o_sum  output  WIDTH  sum bits, registered.
- o_cout  output  1  carry out of MSB, registered.
- o_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB, registered.
- o_busy  output  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: o_ready=1. On edge with i_valid=1:
  - latch i_a, i_b into shift registers;
  - carry register <= i_cin; bit counter <= 0; state -> RUN.
- RUN: each edge:
  - FullAdder inputs are the LSB of the A/B shift regs plus the carry reg.
  - Its sum bit shifts into o_sum from the MSB end; A/B shift right.
  - Carry reg <= FullAdder carry; counter increments.
  - On the edge where counter == WIDTH-1, also capture o_ovf and go to DONE. o_ovf is the pre-update carry reg (carry into MSB) XOR the FullAdder carry. o_cout is the final carry reg.
- DONE: o_valid=1; o_sum/o_cout/o_ovf held stable. On edge with i_ready=1 -> IDLE.
- i_valid is ignored outside IDLE. i_ready is ignored outside DONE.
- No overlap: a new operand is never accepted in the same cycle a result is consumed.
- Arithmetic: result is (i_a + i_b + i_cin) mod 2^WIDTH; o_cout is bit WIDTH of the exact sum.
- Counter width: $clog2(WIDTH+1). WIDTH=1 passes through RUN for exactly one cycle.

## Timing
- Reset values (asynchronous, immediate on i_rst=1):
  - state IDLE, o_ready=1;
  - o_valid=0, o_busy=0;
  - o_sum=0, o_cout=0, o_ovf=0;
  - carry reg, counter and shift regs 0.
- Accept edge T (i_valid & o_ready): o_busy=1 from T to T+WIDTH. o_valid=1 from edge T+WIDTH until the consume edge.
- Latency: WIDTH+1 cycles from accept edge to first cycle the result is consumable. Throughput: one add per WIDTH+2 cycles with no backpressure.
- o_sum may show partial values during RUN; only values while o_valid=1 are defined.
- Reset mid-RUN or mid-DONE: operation aborted, result discarded, no o_valid pulse; IDLE on the first edge after release.
- o_ready and o_valid are decoded from registered state only, with no combinational path from i_valid/i_ready.

## Structure
- Shared package `serial_adder_pkg`: state enum (IDLE, RUN, DONE); legal WIDTH bounds as constants.
- One sub-module: the existing FullAdder, instantiated once as the bit-slice datapath. The controller owns all registers; FullAdder stays purely combinational.
- No other sub-modules; the counter, shift registers and FSM live in this module.

## Test plan
- WIDTH=4, a=3, b=5, cin=0, i_ready=1 -> o_valid at accept+4 edges; o_sum=8, o_cout=0, o_ovf=1.
- WIDTH=4, a=15, b=0, cin=1 -> o_sum=0, o_cout=1, o_ovf=0; o_busy high exactly 4 cycles.
- WIDTH=8, a=200, b=100, cin=0, i_ready held 0 for 5 cycles -> o_valid and o_sum=44, o_cout=1 stay stable all 5 cycles; IDLE one edge after i_ready=1.
- WIDTH=8: pulse i_valid with new operands during RUN and DONE -> ignored; the first result is unchanged and o_ready stays 0 until IDLE.
- WIDTH=8: assert i_rst two cycles into RUN -> all outputs at reset values immediately; no o_valid; the next add 1+1 gives o_sum=2.
- WIDTH=1, a=1, b=1, cin=1 -> o_sum=1, o_cout=1, o_ovf=0, o_valid one edge after accept.
